// File: rtl/design_unit_arbiter.sv
// design_unit_arbiter
// Two-client round-robin arbiter and sequencer for one shared start/result/check
// compute unit. Each client holds one request and one response at a time.
// A watchdog aborts transactions whose check never becomes ready.
module design_unit_arbiter #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST_N,

    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          EN_req0,
    output logic          RDY_req0,
    output logic [DW-1:0] resp0_result,
    output logic [DW-1:0] resp0_check,
    output logic          resp0_err,
    output logic          RDY_resp0,
    input  logic          EN_resp0,

    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic          EN_req1,
    output logic          RDY_req1,
    output logic [DW-1:0] resp1_result,
    output logic [DW-1:0] resp1_check,
    output logic          resp1_err,
    output logic          RDY_resp1,
    input  logic          EN_resp1,

    output logic [DW-1:0] start_a,
    output logic [DW-1:0] start_b,
    output logic          EN_start,
    input  logic          RDY_start,
    input  logic [DW-1:0] result,
    input  logic          RDY_result,
    output logic          EN_check,
    input  logic [DW-1:0] check,
    input  logic          RDY_check
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    localparam logic [15:0] TimerLast = 16'(TIMEOUT - 1);

    state_t        state_q;
    logic          lastGrant_q;
    logic [15:0]   timer_q;

    logic          pend0_q;
    logic          valid0_q;
    logic [DW-1:0] req0A_q;
    logic [DW-1:0] req0B_q;
    logic [DW-1:0] resp0Result_q;
    logic [DW-1:0] resp0Check_q;
    logic          resp0Err_q;

    logic          pend1_q;
    logic          valid1_q;
    logic [DW-1:0] req1A_q;
    logic [DW-1:0] req1B_q;
    logic [DW-1:0] resp1Result_q;
    logic [DW-1:0] resp1Check_q;
    logic          resp1Err_q;

    logic          grant_d;
    logic          rdyReq0;
    logic          rdyReq1;
    logic          enStart;
    logic          enCheck;
    logic          timeout;
    logic          unusedResultRdy;

    // The unit's result-valid flag is informational only; the check handshake defines completion.
    assign unusedResultRdy = RDY_result;

    assign rdyReq0 = !pend0_q && !valid0_q;
    assign rdyReq1 = !pend1_q && !valid1_q;
    assign enStart = (state_q == ST_ISSUE) && RDY_start;
    assign enCheck = (state_q == ST_WAIT) && RDY_check;
    assign timeout = (state_q == ST_WAIT) && !RDY_check && (timer_q == TimerLast);

    assign RDY_req0     = rdyReq0;
    assign RDY_req1     = rdyReq1;
    assign RDY_resp0    = valid0_q;
    assign RDY_resp1    = valid1_q;
    assign resp0_result = resp0Result_q;
    assign resp0_check  = resp0Check_q;
    assign resp0_err    = resp0Err_q;
    assign resp1_result = resp1Result_q;
    assign resp1_check  = resp1Check_q;
    assign resp1_err    = resp1Err_q;
    assign EN_start     = enStart;
    assign EN_check     = enCheck;

    // Round-robin pick: a lone pending client wins, a tie goes to whoever did not win last.
    always_comb begin
        grant_d = lastGrant_q;
        if (pend0_q && pend1_q) begin
            grant_d = !lastGrant_q;
        end else if (pend0_q) begin
            grant_d = 1'b0;
        end else if (pend1_q) begin
            grant_d = 1'b1;
        end
    end

    // Operands of the granted client reach the unit only while issuing.
    always_comb begin
        start_a = '0;
        start_b = '0;
        if (state_q == ST_ISSUE) begin
            start_a = lastGrant_q ? req1A_q : req0A_q;
            start_b = lastGrant_q ? req1B_q : req0B_q;
        end
    end

    // Client request/response bookkeeping plus the IDLE -> ISSUE -> WAIT sequencer and watchdog.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            lastGrant_q   <= 1'b1;
            timer_q       <= '0;
            pend0_q       <= 1'b0;
            valid0_q      <= 1'b0;
            req0A_q       <= '0;
            req0B_q       <= '0;
            resp0Result_q <= '0;
            resp0Check_q  <= '0;
            resp0Err_q    <= 1'b0;
            pend1_q       <= 1'b0;
            valid1_q      <= 1'b0;
            req1A_q       <= '0;
            req1B_q       <= '0;
            resp1Result_q <= '0;
            resp1Check_q  <= '0;
            resp1Err_q    <= 1'b0;
        end else begin
            if (EN_req0 && rdyReq0) begin
                pend0_q <= 1'b1;
                req0A_q <= req0_a;
                req0B_q <= req0_b;
            end
            if (EN_req1 && rdyReq1) begin
                pend1_q <= 1'b1;
                req1A_q <= req1_a;
                req1B_q <= req1_b;
            end
            if (EN_resp0 && valid0_q) begin
                valid0_q <= 1'b0;
            end
            if (EN_resp1 && valid1_q) begin
                valid1_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pend0_q || pend1_q) begin
                        lastGrant_q <= grant_d;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (enStart) begin
                        timer_q <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (enCheck || timeout) begin
                        state_q <= ST_IDLE;
                        if (!lastGrant_q) begin
                            resp0Result_q <= enCheck ? result : '0;
                            resp0Check_q  <= enCheck ? check : '0;
                            resp0Err_q    <= !enCheck;
                            valid0_q      <= 1'b1;
                            pend0_q       <= 1'b0;
                        end else begin
                            resp1Result_q <= enCheck ? result : '0;
                            resp1Check_q  <= enCheck ? check : '0;
                            resp1Err_q    <= !enCheck;
                            valid1_q      <= 1'b1;
                            pend1_q       <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_design_unit_arbiter.sv
// tb_design_unit_arbiter
// Directed bench for the two-client arbiter; the shared unit is played by the
// initial block, which drives RDY_start/RDY_check/result/check by hand.
module tb_design_unit_arbiter;

    localparam int DW      = 8;
    localparam int TIMEOUT = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          EN_req0 = 1'b0, EN_req1 = 1'b0, EN_resp0 = 1'b0, EN_resp1 = 1'b0;
    logic          RDY_req0, RDY_req1, RDY_resp0, RDY_resp1;
    logic [DW-1:0] resp0_result, resp0_check, resp1_result, resp1_check;
    logic          resp0_err, resp1_err;
    logic [DW-1:0] start_a, start_b;
    logic          EN_start, EN_check;
    logic          RDY_start = 1'b1, RDY_result = 1'b0, RDY_check = 1'b0;
    logic [DW-1:0] result = '0, check = '0;

    int testsRun = 0;
    int testsFailed = 0;

    design_unit_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0_a(req0_a), .req0_b(req0_b), .EN_req0(EN_req0), .RDY_req0(RDY_req0),
        .resp0_result(resp0_result), .resp0_check(resp0_check), .resp0_err(resp0_err),
        .RDY_resp0(RDY_resp0), .EN_resp0(EN_resp0),
        .req1_a(req1_a), .req1_b(req1_b), .EN_req1(EN_req1), .RDY_req1(RDY_req1),
        .resp1_result(resp1_result), .resp1_check(resp1_check), .resp1_err(resp1_err),
        .RDY_resp1(RDY_resp1), .EN_resp1(EN_resp1),
        .start_a(start_a), .start_b(start_b), .EN_start(EN_start), .RDY_start(RDY_start),
        .result(result), .RDY_result(RDY_result), .EN_check(EN_check),
        .check(check), .RDY_check(RDY_check)
    );

    // Free-running 10 ns clock
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int client, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (client == 0) begin
            EN_req0 = 1'b1; req0_a = a; req0_b = b;
        end else begin
            EN_req1 = 1'b1; req1_a = a; req1_b = b;
        end
        tick();
        EN_req0 = 1'b0;
        EN_req1 = 1'b0;
    endtask

    task automatic applyBoth(input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                             input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        EN_req0 = 1'b1; req0_a = a0; req0_b = b0;
        EN_req1 = 1'b1; req1_a = a1; req1_b = b1;
        tick();
        EN_req0 = 1'b0;
        EN_req1 = 1'b0;
    endtask

    task automatic waitForStart(input logic [DW-1:0] expA, input logic [DW-1:0] expB);
        int waited = 0;
        while (EN_start !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("enStart", EN_start, 1);
        checkOutput("startA", start_a, expA);
        checkOutput("startB", start_b, expB);
        checkOutput("enCheckInIssue", EN_check, 0);
    endtask

    task automatic serviceOne(input int client, input logic [DW-1:0] expA, input logic [DW-1:0] expB,
                              input logic [DW-1:0] res, input logic [DW-1:0] chk, input bit consume);
        waitForStart(expA, expB);
        tick();
        checkOutput("enStartInWait", EN_start, 0);
        checkOutput("startAInWait", start_a, 0);
        RDY_check = 1'b1; result = res; check = chk;
        #1;
        checkOutput("enCheck", EN_check, 1);
        tick();
        checkOutput("enCheckAfterDone", EN_check, 0);
        RDY_check = 1'b0; result = '0; check = '0;
        if (client == 0) begin
            checkOutput("rdyResp0", RDY_resp0, 1);
            checkOutput("resp0Result", resp0_result, res);
            checkOutput("resp0Check", resp0_check, chk);
            checkOutput("resp0Err", resp0_err, 0);
            if (consume) begin
                EN_resp0 = 1'b1;
                tick();
                EN_resp0 = 1'b0;
                checkOutput("resp0Consumed", RDY_resp0, 0);
            end
        end else begin
            checkOutput("rdyResp1", RDY_resp1, 1);
            checkOutput("resp1Result", resp1_result, res);
            checkOutput("resp1Check", resp1_check, chk);
            checkOutput("resp1Err", resp1_err, 0);
            if (consume) begin
                EN_resp1 = 1'b1;
                tick();
                EN_resp1 = 1'b0;
                checkOutput("resp1Consumed", RDY_resp1, 0);
            end
        end
    endtask

    task automatic resetDut();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    // Directed sequence covering reset, single and contended transactions, stalls, timeout and async reset
    initial begin
        logic [DW-1:0] r8;

        // Reset values while RST_N is held low
        #12;
        checkOutput("resetRdyReq0", RDY_req0, 1);
        checkOutput("resetRdyReq1", RDY_req1, 1);
        checkOutput("resetRdyResp0", RDY_resp0, 0);
        checkOutput("resetRdyResp1", RDY_resp1, 0);
        checkOutput("resetEnStart", EN_start, 0);
        checkOutput("resetEnCheck", EN_check, 0);
        checkOutput("resetStartA", start_a, 0);
        checkOutput("resetStartB", start_b, 0);
        tick();
        RST_N = 1'b1;

        // 1: single client-0 transaction with minimum latency
        applyStimulus(0, 8'h12, 8'h34);
        checkOutput("t1RdyReq0Busy", RDY_req0, 0);
        checkOutput("t1NoStartYet", EN_start, 0);
        tick();
        checkOutput("t1StartAtT2", EN_start, 1);
        serviceOne(0, 8'h12, 8'h34, 8'h46, 8'h5A, 1'b1);
        checkOutput("t1RdyReq0Back", RDY_req0, 1);

        // 2: simultaneous requests, grant order 0,1 each round after reset
        resetDut();
        for (int r = 0; r < 3; r++) begin
            r8 = 8'(r);
            applyBoth(8'h10 + r8, 8'h20 + r8, 8'hA0 + r8, 8'h05 + r8);
            serviceOne(0, 8'h10 + r8, 8'h20 + r8, 8'h30 + r8, 8'h40 + r8, 1'b1);
            serviceOne(1, 8'hA0 + r8, 8'h05 + r8, 8'hB0 + r8, 8'hC0 + r8, 1'b1);
        end

        // 3: unit not ready to start for 10 cycles
        RDY_start = 1'b0;
        applyStimulus(0, 8'h5C, 8'h0F);
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("t3StallEnStart", EN_start, 0);
            checkOutput("t3StallStartA", start_a, 8'h5C);
            checkOutput("t3StallStartB", start_b, 8'h0F);
            tick();
        end
        RDY_start = 1'b1;
        #1;
        checkOutput("t3FirstReadyFires", EN_start, 1);
        serviceOne(0, 8'h5C, 8'h0F, 8'h6B, 8'h53, 1'b1);

        // 4: watchdog abort on client 1, then a normal transaction
        applyStimulus(1, 8'h77, 8'h11);
        waitForStart(8'h77, 8'h11);
        tick();
        result = 8'hEE; check = 8'hEE;
        for (int i = 0; i < TIMEOUT; i++) begin
            checkOutput("t4NoEnCheck", EN_check, 0);
            checkOutput("t4NoRespYet", RDY_resp1, 0);
            tick();
        end
        result = '0; check = '0;
        checkOutput("t4RdyResp1", RDY_resp1, 1);
        checkOutput("t4Err", resp1_err, 1);
        checkOutput("t4ResultZero", resp1_result, 0);
        checkOutput("t4CheckZero", resp1_check, 0);
        checkOutput("t4IdleEnStart", EN_start, 0);
        EN_resp1 = 1'b1;
        tick();
        EN_resp1 = 1'b0;
        applyStimulus(1, 8'h21, 8'h43);
        serviceOne(1, 8'h21, 8'h43, 8'h64, 8'h99, 1'b1);

        // 5: unconsumed response blocks only its own client
        applyStimulus(0, 8'h0A, 8'h0B);
        serviceOne(0, 8'h0A, 8'h0B, 8'hC1, 8'hC2, 1'b0);
        checkOutput("t5RdyReq0Blocked", RDY_req0, 0);
        applyStimulus(0, 8'hFF, 8'hFF);
        checkOutput("t5IgnoredNoStart", EN_start, 0);
        tick();
        checkOutput("t5IgnoredNoStart2", EN_start, 0);
        applyStimulus(1, 8'h30, 8'h40);
        serviceOne(1, 8'h30, 8'h40, 8'h70, 8'h0C, 1'b1);
        checkOutput("t5Resp0Held", RDY_resp0, 1);
        checkOutput("t5Resp0Value", resp0_result, 8'hC1);
        EN_resp0 = 1'b1;
        tick();
        EN_resp0 = 1'b0;
        checkOutput("t5RdyReq0Back", RDY_req0, 1);
        checkOutput("t5Resp0Gone", RDY_resp0, 0);
        checkOutput("t5NoStaleStart", EN_start, 0);

        // 6: asynchronous reset during WAIT
        applyStimulus(0, 8'h3C, 8'h4D);
        waitForStart(8'h3C, 8'h4D);
        tick();
        RDY_check = 1'b1;
        #1;
        checkOutput("t6EnCheckBefore", EN_check, 1);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("t6EnCheckKilled", EN_check, 0);
        checkOutput("t6RdyReq0", RDY_req0, 1);
        checkOutput("t6RdyReq1", RDY_req1, 1);
        checkOutput("t6RdyResp0", RDY_resp0, 0);
        checkOutput("t6RdyResp1", RDY_resp1, 0);
        RDY_check = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t6NoStaleResp0", RDY_resp0, 0);
            checkOutput("t6NoStart", EN_start, 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
